// File: rtl/mac_pe_vec.sv
// mac_pe_vec: vector multiply-accumulate PE, LANES lanes sharing scalar b.
// Each lane computes c + sum(a_k*b_k) mod 2^WIDTH over len terms.
// Ports: clk, rst (sync, active-high); start/len/c open a run;
//   in_valid/in_ready/a/b stream terms; out_valid/out_ready/result
//   return the per-lane sums; busy is high outside IDLE.
// Optional macro MAC_PE_SUB_EN adds port sub: result = c - sum(a_k*b_k).
module mac_pe_vec #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int LEN_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef MAC_PE_SUB_EN
  input  logic                   sub,
`endif
  input  logic [LEN_W-1:0]       len,
  input  logic [LANES*WIDTH-1:0] c,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  logic [WIDTH-1:0] acc     [LANES];
  logic [WIDTH-1:0] prod    [LANES];
  logic [WIDTH-1:0] mul     [LANES];
  logic [WIDTH-1:0] acc_upd [LANES];
  logic             prod_v;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             accept;
`ifdef MAC_PE_SUB_EN
  logic             sub_q;
`endif

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == RUN);

  // Products are truncated to WIDTH; the accumulate step runs one
  // cycle behind the multiply, so the last product lands in DRAIN.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mul[i] = a[i*WIDTH +: WIDTH] * b;
`ifdef MAC_PE_SUB_EN
      acc_upd[i] = sub_q ? (acc[i] - prod[i])
                         : (acc[i] + prod[i]);
`else
      acc_upd[i] = acc[i] + prod[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prod_v    <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
`ifdef MAC_PE_SUB_EN
      sub_q     <= 1'b0;
`endif
      for (int i = 0; i < LANES; i++) begin
        acc[i]  <= '0;
        prod[i] <= '0;
      end
    end else begin
      prod_v <= accept;
      if (prod_v) begin
        for (int i = 0; i < LANES; i++)
          acc[i] <= acc_upd[i];
      end
      if (accept) begin
        cnt <= cnt + ONE;
        for (int i = 0; i < LANES; i++)
          prod[i] <= mul[i];
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            len_q <= len;
`ifdef MAC_PE_SUB_EN
            sub_q <= sub;
`endif
            for (int i = 0; i < LANES; i++)
              acc[i] <= c[i*WIDTH +: WIDTH];
            state <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept && (cnt == len_q - ONE))
            state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes acc; then wait for out_ready.
          if (!out_valid) begin
            out_valid <= 1'b1;
            for (int i = 0; i < LANES; i++)
              result[i*WIDTH +: WIDTH] <= acc[i];
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_pe_vec.sv
// tb_mac_pe_vec: directed + randomized checks of mac_pe_vec against
// an arithmetic dot-product reference.
module tb_mac_pe_vec;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int LEN_W = 12;
  localparam int VW    = LANES * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [VW-1:0]    c = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VW-1:0]    result;
  logic             busy;
`ifdef MAC_PE_SUB_EN
  logic             sub_r = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [VW-1:0]    ta [16];
  logic [WIDTH-1:0] tb_b [16];

  mac_pe_vec #(.WIDTH(WIDTH), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef MAC_PE_SUB_EN
    .sub(sub_r),
`endif
    .len(len),
    .c(c),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] lane_fill(input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  // Reference: c +/- sum(a_k*b_k) per lane, reduced mod 2^WIDTH.
  function automatic logic [VW-1:0] model(input int n,
                                          input logic [VW-1:0] cv,
                                          input bit sb);
    logic [VW-1:0] r;
    longint s, p;
    for (int i = 0; i < LANES; i++) begin
      s = longint'(cv[i*WIDTH +: WIDTH]);
      for (int k = 0; k < n; k++) begin
        p = longint'(ta[k][i*WIDTH +: WIDTH]) * longint'(tb_b[k]);
        s = sb ? s - p : s + p;
      end
      s = s % 65536;
      if (s < 0) s = s + 65536;
      r[i*WIDTH +: WIDTH] = WIDTH'(s);
    end
    return r;
  endfunction

  task automatic do_run(input string tag, input int n,
                        input logic [VW-1:0] cv, input bit sb,
                        input bit gaps, input int hold);
    logic [VW-1:0] exp;
    logic [VW-1:0] held;
    int w;
    exp = model(n, cv, sb);
    start = 1'b1;
    len   = LEN_W'(n);
    c     = cv;
`ifdef MAC_PE_SUB_EN
    sub_r = sb;
`endif
    step();
    start = 1'b0;
    c     = VW'({$urandom, $urandom});
    chk({tag, "_busy"}, VW'(busy), VW'(1));
    if (n == 0) begin
      chk({tag, "_len0_rdy"}, VW'(in_ready), VW'(0));
      chk({tag, "_len0_ov0"}, VW'(out_valid), VW'(0));
      step();
    end else begin
      for (int k = 0; k < n; k++) begin
        if (gaps) begin
          w = $urandom_range(0, 2);
          for (int g = 0; g < w; g++) begin
            a = VW'({$urandom, $urandom});
            b = WIDTH'($urandom);
            step();
          end
        end
        in_valid = 1'b1;
        a = ta[k];
        b = tb_b[k];
        w = 0;
        while (!in_ready && w < 50) begin
          step();
          w++;
        end
        if (w >= 50) chk({tag, "_rdy_timeout"}, VW'(0), VW'(1));
        step();
        in_valid = 1'b0;
      end
      chk({tag, "_lat0"}, VW'(out_valid), VW'(0));
      chk({tag, "_drain_rdy"}, VW'(in_ready), VW'(0));
      step();
      chk({tag, "_lat1"}, VW'(out_valid), VW'(0));
      step();
    end
    chk({tag, "_ov"}, VW'(out_valid), VW'(1));
    chk({tag, "_res"}, result, exp);
    held = result;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = LEN_W'($urandom_range(0, 3));
      step();
      chk({tag, "_hold_res"}, result, exp);
      chk({tag, "_hold_ov"}, VW'(out_valid), VW'(1));
      chk({tag, "_hold_busy"}, VW'(busy), VW'(1));
    end
    start = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_done_ov"}, VW'(out_valid), VW'(0));
    chk({tag, "_done_busy"}, VW'(busy), VW'(0));
    step();
    chk({tag, "_idle_busy"}, VW'(busy), VW'(0));
    chk({tag, "_idle_res"}, result, held);
  endtask

  initial begin
    int n;
    logic [VW-1:0] cv;
    step();
    step();
    rst = 1'b0;
    chk("rst_rdy", VW'(in_ready), VW'(0));
    chk("rst_ov", VW'(out_valid), VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_res", result, VW'(0));

    // scenario 1: [57,58,59,60]
    ta[0] = lane_fill(16'd2); tb_b[0] = 16'd5;
    ta[1] = lane_fill(16'd3); tb_b[1] = 16'd6;
    ta[2] = lane_fill(16'd4); tb_b[2] = 16'd7;
    cv = {16'd4, 16'd3, 16'd2, 16'd1};
    do_run("s1", 3, cv, 1'b0, 1'b0, 0);
    chk("s1_const", result, {16'd60, 16'd59, 16'd58, 16'd57});

    // wrap cases
    ta[0] = lane_fill(16'hFFFF); tb_b[0] = 16'hFFFF;
    do_run("wrap0", 1, VW'(0), 1'b0, 1'b0, 0);
    chk("wrap0_const", result, lane_fill(16'h0001));
    do_run("wrap1", 1, lane_fill(16'hFFFF), 1'b0, 1'b0, 0);
    chk("wrap1_const", result, lane_fill(16'h0000));

    // len 0 returns c
    do_run("len0", 0, {16'd6, 16'd7, 16'd8, 16'd9}, 1'b0, 1'b0, 1);
    chk("len0_const", result, {16'd6, 16'd7, 16'd8, 16'd9});

    // gaps and backpressure
    for (int k = 0; k < 4; k++) begin
      ta[k] = VW'({$urandom, $urandom});
      tb_b[k] = WIDTH'($urandom);
    end
    do_run("bp", 4, VW'({$urandom, $urandom}), 1'b0, 1'b1, 5);

    // reset mid-run after 2 of 5 terms
    start = 1'b1; len = 12'd5; c = lane_fill(16'd77);
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      a = lane_fill(16'd9);
      b = 16'd9;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rdy", VW'(in_ready), VW'(0));
    chk("mrst_ov", VW'(out_valid), VW'(0));
    chk("mrst_busy", VW'(busy), VW'(0));
    chk("mrst_res", result, VW'(0));
    ta[0] = lane_fill(16'd3); tb_b[0] = 16'd4;
    do_run("post_rst", 1, VW'(0), 1'b0, 1'b0, 0);
    chk("post_rst_const", result, lane_fill(16'd12));

`ifdef MAC_PE_SUB_EN
    ta[0] = lane_fill(16'd3); tb_b[0] = 16'd4;
    ta[1] = lane_fill(16'd3); tb_b[1] = 16'd4;
    do_run("sub1", 2, lane_fill(16'd100), 1'b1, 1'b0, 0);
    chk("sub1_const", result, lane_fill(16'd76));
    ta[0] = lane_fill(16'd1); tb_b[0] = 16'd1;
    do_run("sub2", 1, VW'(0), 1'b1, 1'b0, 0);
    chk("sub2_const", result, lane_fill(16'hFFFF));
    ta[0] = lane_fill(16'd2); tb_b[0] = 16'd5;
    ta[1] = lane_fill(16'd3); tb_b[1] = 16'd6;
    ta[2] = lane_fill(16'd4); tb_b[2] = 16'd7;
    do_run("sub0", 3, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 0);
    chk("sub0_const", result, {16'd60, 16'd59, 16'd58, 16'd57});
`endif

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) begin
        ta[k] = VW'({$urandom, $urandom});
        tb_b[k] = WIDTH'($urandom);
      end
      cv = VW'({$urandom, $urandom});
`ifdef MAC_PE_SUB_EN
      do_run("rnd", n, cv, bit'($urandom_range(0, 1)), 1'b1,
             $urandom_range(0, 3));
`else
      do_run("rnd", n, cv, 1'b0, 1'b1, $urandom_range(0, 3));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
